// File: rtl/iec_sd_server_pkg.sv
// Shared types and helpers for the IEC drive block-interface server.
package iec_sd_pkg;

  localparam int MAX_DRIVES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    RREQ  = 3'd2,
    RPUT  = 3'd3,
    WADDR = 3'd4,
    WCAP  = 3'd5,
    WREQ  = 3'd6,
    DONE  = 3'd7
  } sds_t;

  function automatic int ndr(input int drives);
    if (drives < 1) return 1;
    if (drives > MAX_DRIVES) return MAX_DRIVES;
    return drives;
  endfunction

endpackage

// File: rtl/iec_sd_server_if.sv
// Drive-side block bus (server is slave) and image-memory bus (server is master).
interface iec_sd_drv_if #(parameter int NDR = 2);
  logic [NDR-1:0] img_mounted;
  logic [31:0]    img_size;
  logic           img_readonly;
  logic [31:0]    sd_lba      [NDR];
  logic [5:0]     sd_blk_cnt  [NDR];
  logic [NDR-1:0] sd_rd;
  logic [NDR-1:0] sd_wr;
  logic [NDR-1:0] sd_ack;
  logic [13:0]    sd_buff_addr;
  logic [7:0]     sd_buff_dout;
  logic [7:0]     sd_buff_din [NDR];
  logic           sd_buff_wr;

  modport master (
    output img_mounted, img_size, img_readonly, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
  modport slave (
    input  img_mounted, img_size, img_readonly, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

interface iec_sd_mem_if #(parameter int AW = 22);
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_ack;

  modport master (
    output mem_addr, mem_req, mem_we, mem_din,
    input  mem_dout, mem_ack
  );
  modport slave (
    input  mem_addr, mem_req, mem_we, mem_din,
    output mem_dout, mem_ack
  );
endinterface

// File: rtl/iec_sd_server_rr_arb.sv
// NDR-way round-robin arbiter: combinational pick starting at a registered pointer.
module iec_sd_rr_arb #(
  parameter int NDR = 2,
  parameter int IW  = 1
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [NDR-1:0] i_req,
  input  logic           i_advance,
  output logic [NDR-1:0] o_grant,
  output logic [IW-1:0]  o_grant_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int off = 0; off < NDR; off++) begin
      int v_idx;
      v_idx = (int'(r_ptr) + off) % NDR;
      if (!w_found && i_req[v_idx]) begin
        w_found        = 1'b1;
        o_grant[v_idx] = 1'b1;
        o_grant_idx    = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (o_grant_idx == IW'(NDR - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/iec_sd_server.sv
// Serves per-drive block read/write requests from disk-image regions in byte-wide memory.
//  state | meaning
//  IDLE  | wait for any drive request, grant and capture parameters
//  ACK   | raise sd_ack for the granted drive, k = 0
//  RREQ  | fetch byte k from memory (or substitute 0x00 when out of range)
//  RPUT  | strobe byte k into the drive buffer
//  WADDR | present k on sd_buff_addr
//  WCAP  | capture drive data, decide whether memory is written
//  WREQ  | write byte k to memory
//  DONE  | sd_ack low, wait for the served drive to drop its request
module iec_sd_server
  import iec_sd_pkg::*;
#(
  parameter int DRIVES    = 2,
  parameter int BLK_LOG2  = 8,
  parameter int SPAN_LOG2 = 20,
  parameter int AW        = 22
) (
  input  logic clk_sys,
  input  logic reset_n,
  iec_sd_drv_if.slave  drv,
  iec_sd_mem_if.master mem
);

  localparam int NDR = ndr(DRIVES);
  localparam int IW  = (NDR > 1) ? $clog2(NDR) : 1;

  sds_t           r_state;
  sds_t           w_state_nxt;
  logic [31:0]    r_size [NDR];
  logic [NDR-1:0] r_ro;
  logic [IW-1:0]  r_drv;
  logic           r_rd;
  logic [14:0]    r_len;
  logic [31:0]    r_base;
  logic [13:0]    r_k;
  logic [7:0]     r_data;
  logic [NDR-1:0] r_ack;
  logic           r_req_hold;

  logic [NDR-1:0] w_grant;
  logic [IW-1:0]  w_grant_idx;
  logic           w_advance;
  logic           w_any_req;
  logic [31:0]    w_off;
  logic           w_in_range;
  logic           w_last;
  logic           w_wr_skip;
  logic           w_mem_req;
  logic           w_mem_we;
  logic [AW-1:0]  w_mem_addr;
  logic [14:0]    w_len;
  logic [31:0]    w_base;

  assign w_any_req  = |(drv.sd_rd | drv.sd_wr);
  assign w_off      = r_base + {18'd0, r_k};
  assign w_in_range = (w_off < r_size[r_drv]);
  assign w_last     = ({1'b0, r_k} == (r_len - 15'd1));
  assign w_wr_skip  = !w_in_range || r_ro[r_drv];
  assign w_len      = 15'((15'(drv.sd_blk_cnt[w_grant_idx]) + 15'd1) << BLK_LOG2);
  assign w_base     = drv.sd_lba[w_grant_idx] << BLK_LOG2;

  always_comb begin
    w_mem_addr                  = AW'(r_drv) << SPAN_LOG2;
    w_mem_addr[SPAN_LOG2-1:0]   = w_off[SPAN_LOG2-1:0];
  end

  // Pointer moves at grant time; nothing re-arbitrates before the transfer completes,
  // so this is indistinguishable from advancing at completion.
  iec_sd_rr_arb #(.NDR(NDR), .IW(IW)) u_arb (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .i_req       (drv.sd_rd | drv.sd_wr),
    .i_advance   (w_advance),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACK;
          w_advance   = 1'b1;
        end
      end
      ACK:   w_state_nxt = r_rd ? RREQ : WADDR;
      RREQ: begin
        // Once a fetch is issued it is held to completion even if a remount shrinks the image.
        if (!w_in_range && !r_req_hold) begin
          w_state_nxt = RPUT;
        end else begin
          w_mem_req = 1'b1;
          if (mem.mem_ack) w_state_nxt = RPUT;
        end
      end
      RPUT:  w_state_nxt = w_last ? DONE : RREQ;
      WADDR: w_state_nxt = WCAP;
      WCAP: begin
        if (w_wr_skip) w_state_nxt = w_last ? DONE : WADDR;
        else           w_state_nxt = WREQ;
      end
      WREQ: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        if (mem.mem_ack) w_state_nxt = w_last ? DONE : WADDR;
      end
      DONE: begin
        if (!(drv.sd_rd[r_drv] | drv.sd_wr[r_drv])) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NDR; i++) r_size[i] <= '0;
      r_ro <= '1;
    end else begin
      for (int i = 0; i < NDR; i++) begin
        if (drv.img_mounted[i]) begin
          r_size[i] <= drv.img_size;
          r_ro[i]   <= drv.img_readonly;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_drv      <= '0;
      r_rd       <= 1'b0;
      r_len      <= '0;
      r_base     <= '0;
      r_k        <= '0;
      r_data     <= '0;
      r_ack      <= '0;
      r_req_hold <= 1'b0;
    end else begin
      r_req_hold <= (r_state == RREQ) && w_mem_req && !mem.mem_ack;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_drv  <= w_grant_idx;
            r_rd   <= |(w_grant & drv.sd_rd);
            r_len  <= w_len;
            r_base <= w_base;
            r_k    <= '0;
          end
        end
        ACK: begin
          for (int i = 0; i < NDR; i++) r_ack[i] <= (r_drv == IW'(i));
          r_k <= '0;
        end
        RREQ: begin
          if (!w_in_range && !r_req_hold) r_data <= 8'h00;
          else if (mem.mem_ack)           r_data <= mem.mem_dout;
        end
        RPUT: begin
          if (w_last) r_ack <= '0;
          else        r_k   <= r_k + 14'd1;
        end
        WCAP: begin
          r_data <= drv.sd_buff_din[r_drv];
          if (w_wr_skip) begin
            if (w_last) r_ack <= '0;
            else        r_k   <= r_k + 14'd1;
          end
        end
        WREQ: begin
          if (mem.mem_ack) begin
            if (w_last) r_ack <= '0;
            else        r_k   <= r_k + 14'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign drv.sd_ack       = r_ack;
  assign drv.sd_buff_addr = r_k;
  assign drv.sd_buff_dout = r_data;
  assign drv.sd_buff_wr   = (r_state == RPUT);
  assign mem.mem_req      = w_mem_req;
  assign mem.mem_we       = w_mem_we;
  assign mem.mem_addr     = w_mem_addr;
  assign mem.mem_din      = r_data;

endmodule

// File: tb/tb_iec_sd_server.sv
// Scoreboard bench for iec_sd_server: stimulus pushes expected events, a monitor pops and compares.
module tb_iec_sd_server;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  iec_sd_drv_if #(.NDR(2))  drv();
  iec_sd_mem_if #(.AW(22))  mem();

  iec_sd_server #(.DRIVES(2), .BLK_LOG2(8), .SPAN_LOG2(20), .AW(22)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .drv     (drv),
    .mem     (mem)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [21:0] exp_sd_q  [$];
  logic [30:0] exp_mem_q [$];
  logic [1:0]  exp_gnt_q [$];

  int   strobe_cyc [512];
  int   first_mack, last_mack, ack_fall_cyc, req_pulses;
  logic mack_seen;
  logic [1:0] prev_ack;
  logic prev_req;

  always @(posedge clk_sys) cyc++;

  // zero-wait memory: ack one cycle after req, data = low address byte
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem.mem_ack  <= 1'b0;
      mem.mem_dout <= 8'h00;
    end else begin
      mem.mem_ack  <= mem.mem_req && !mem.mem_ack;
      mem.mem_dout <= mem.mem_addr[7:0];
    end
  end

  // drive buffers: data = ~addr, one cycle behind the address
  always @(posedge clk_sys) begin
    drv.sd_buff_din[0] <= ~drv.sd_buff_addr[7:0];
    drv.sd_buff_din[1] <= ~drv.sd_buff_addr[7:0];
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (drv.sd_buff_wr) begin
        strobe_cyc[drv.sd_buff_addr[8:0]] = cyc;
        if (exp_sd_q.size() == 0)
          check("sd_strobe_unexpected", 32'({drv.sd_buff_addr, drv.sd_buff_dout}), 32'h3FFFFF);
        else
          check("sd_strobe", 32'({drv.sd_buff_addr, drv.sd_buff_dout}), 32'(exp_sd_q.pop_front()));
      end
      if (mem.mem_req && mem.mem_ack) begin
        if (!mack_seen) first_mack = cyc;
        mack_seen = 1'b1;
        last_mack = cyc;
        if (exp_mem_q.size() == 0)
          check("mem_txn_unexpected", 32'({mem.mem_we, mem.mem_addr, mem.mem_we ? mem.mem_din : 8'h00}), 32'h7FFFFFFF);
        else
          check("mem_txn", 32'({mem.mem_we, mem.mem_addr, mem.mem_we ? mem.mem_din : 8'h00}), 32'(exp_mem_q.pop_front()));
      end
      if (drv.sd_ack != 2'b00 && prev_ack == 2'b00) begin
        if (exp_gnt_q.size() == 0) check("grant_unexpected", 32'(drv.sd_ack), 32'h0);
        else                       check("grant", 32'(drv.sd_ack), 32'(exp_gnt_q.pop_front()));
      end
      if (drv.sd_ack == 2'b00 && prev_ack != 2'b00) ack_fall_cyc = cyc;
      if (mem.mem_req && !prev_req) req_pulses++;
    end
    prev_ack = reset_n ? drv.sd_ack : 2'b00;
    prev_req = reset_n ? mem.mem_req : 1'b0;
  end

  task automatic push_read(input int d, input int lba, input int n, input logic [31:0] size);
    logic [31:0] off;
    logic [21:0] a;
    logic [7:0]  dat;
    for (int k = 0; k < n; k++) begin
      off = 32'(lba * 256 + k);
      a = 22'(d) << 20;
      a[19:0] = off[19:0];
      if (off < size) begin
        exp_mem_q.push_back({1'b0, a, 8'h00});
        dat = off[7:0];
      end else begin
        dat = 8'h00;
      end
      exp_sd_q.push_back({14'(k), dat});
    end
    exp_gnt_q.push_back(2'(1 << d));
  endtask

  task automatic push_write(input int d, input int lba, input int n, input logic [31:0] size, input logic ro);
    logic [31:0] off;
    logic [21:0] a;
    logic [7:0]  kb;
    for (int k = 0; k < n; k++) begin
      off = 32'(lba * 256 + k);
      a = 22'(d) << 20;
      a[19:0] = off[19:0];
      kb = 8'(k);
      if (!ro && off < size) exp_mem_q.push_back({1'b1, a, ~kb});
    end
    exp_gnt_q.push_back(2'(1 << d));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input int d, input logic [31:0] size, input logic ro);
    @(posedge clk_sys); #1;
    drv.img_mounted  = 2'(1 << d);
    drv.img_size     = size;
    drv.img_readonly = ro;
    @(posedge clk_sys); #1;
    drv.img_mounted  = 2'b00;
  endtask

  task automatic wait_ack(input logic want_hi, input int limit, input string nm);
    int n;
    n = 0;
    while (((drv.sd_ack != 2'b00) != want_hi) && n < limit) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(nm, 32'(drv.sd_ack != 2'b00), 32'(want_hi));
  endtask

  task automatic do_xfer(input int d, input logic rd, input int lba, input int cnt);
    @(posedge clk_sys); #1;
    drv.sd_lba[d]     = 32'(lba);
    drv.sd_blk_cnt[d] = 6'(cnt);
    if (rd) drv.sd_rd[d] = 1'b1;
    else    drv.sd_wr[d] = 1'b1;
    wait_ack(1'b1, 100, "ack_rise_timeout");
    wait_ack(1'b0, 10000, "ack_fall_timeout");
    drv.sd_rd[d] = 1'b0;
    drv.sd_wr[d] = 1'b0;
    idle(3);
  endtask

  task automatic chk_reset_outputs(input string nm);
    check({nm, "_sd_ack"},    32'(drv.sd_ack),       32'h0);
    check({nm, "_buff_wr"},   32'(drv.sd_buff_wr),   32'h0);
    check({nm, "_buff_addr"}, 32'(drv.sd_buff_addr), 32'h0);
    check({nm, "_buff_dout"}, 32'(drv.sd_buff_dout), 32'h0);
    check({nm, "_mem_req"},   32'(mem.mem_req),      32'h0);
    check({nm, "_mem_we"},    32'(mem.mem_we),       32'h0);
    check({nm, "_mem_addr"},  32'(mem.mem_addr),     32'h0);
    check({nm, "_mem_din"},   32'(mem.mem_din),      32'h0);
  endtask

  task automatic chk_drained(input string nm);
    check({nm, "_sd_q_left"},  32'(exp_sd_q.size()),  32'h0);
    check({nm, "_mem_q_left"}, 32'(exp_mem_q.size()), 32'h0);
    check({nm, "_gnt_q_left"}, 32'(exp_gnt_q.size()), 32'h0);
  endtask

  initial begin : main
    int p;
    int d;
    logic hit;
    reset_n          = 1'b0;
    mack_seen        = 1'b0;
    req_pulses       = 0;
    drv.img_mounted  = 2'b00;
    drv.img_size     = 32'h0;
    drv.img_readonly = 1'b0;
    drv.sd_rd        = 2'b00;
    drv.sd_wr        = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drv.sd_lba[i]     = 32'h0;
      drv.sd_blk_cnt[i] = 6'h0;
    end
    idle(3);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    idle(2);

    // drive 0 read, lba 3: latency, data, addresses, 3-cycle byte rate
    mount(0, 32'h0010_0000, 1'b0);
    push_read(0, 3, 256, 32'h0010_0000);
    @(posedge clk_sys); #1;
    drv.sd_lba[0]     = 32'd3;
    drv.sd_blk_cnt[0] = 6'd0;
    drv.sd_rd[0]      = 1'b1;
    @(posedge clk_sys); #1;
    check("ack_t+1", 32'(drv.sd_ack), 32'h0);
    @(posedge clk_sys); #1;
    check("ack_t+2", 32'(drv.sd_ack), 32'h1);
    wait_ack(1'b0, 10000, "ack_fall_timeout");
    drv.sd_rd[0] = 1'b0;
    idle(3);
    check("rd_byte_rate", 32'(strobe_cyc[255] - strobe_cyc[0]), 32'd765);
    check("rd_ack_fall",  32'(ack_fall_cyc - strobe_cyc[255]), 32'd1);
    chk_drained("rd");

    // partial image: bytes 128..255 of lba 1 beyond size 0x180
    mount(0, 32'h0000_0180, 1'b0);
    push_read(0, 1, 256, 32'h0000_0180);
    p = req_pulses;
    do_xfer(0, 1'b1, 1, 0);
    check("oor_req_count", 32'(req_pulses - p), 32'd128);
    check("oor_byte_rate", 32'(strobe_cyc[255] - strobe_cyc[127]), 32'd256);
    chk_drained("oor");

    // drive 1 write, two blocks at lba 2
    mount(1, 32'h0010_0000, 1'b0);
    push_write(1, 2, 512, 32'h0010_0000, 1'b0);
    mack_seen = 1'b0;
    do_xfer(1, 1'b0, 2, 1);
    check("wr_byte_rate", 32'(last_mack - first_mack), 32'd2044);
    chk_drained("wr");

    // same write, write-protected: no memory traffic
    mount(1, 32'h0010_0000, 1'b1);
    push_write(1, 2, 512, 32'h0010_0000, 1'b1);
    p = req_pulses;
    do_xfer(1, 1'b0, 2, 1);
    check("ro_req_count", 32'(req_pulses - p), 32'd0);
    chk_drained("ro");

    // simultaneous requests, re-requested after each completion
    push_read(0, 0, 256, 32'h0000_0180);
    push_read(1, 0, 256, 32'h0010_0000);
    push_read(0, 0, 256, 32'h0000_0180);
    push_read(1, 0, 256, 32'h0010_0000);
    drv.sd_lba[0] = 32'd0; drv.sd_blk_cnt[0] = 6'd0;
    drv.sd_lba[1] = 32'd0; drv.sd_blk_cnt[1] = 6'd0;
    @(posedge clk_sys); #1;
    drv.sd_rd = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b1, 100, "rr_ack_rise_timeout");
      d = drv.sd_ack[1] ? 1 : 0;
      wait_ack(1'b0, 10000, "rr_ack_fall_timeout");
      drv.sd_rd[d] = 1'b0;
      idle(2);
      if (i < 2) drv.sd_rd[d] = 1'b1;
    end
    drv.sd_rd = 2'b00;
    idle(3);
    chk_drained("rr");

    // reset in the middle of a read, then a fresh transfer from byte 0
    push_read(0, 0, 256, 32'h0000_0180);
    @(posedge clk_sys); #1;
    drv.sd_rd[0] = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clk_sys);
      if (drv.sd_buff_wr && drv.sd_buff_addr == 14'd100) hit = 1'b1;
    end
    check("rst_reached_byte100", 32'(hit), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    drv.sd_rd = 2'b00;
    exp_sd_q.delete();
    exp_mem_q.delete();
    exp_gnt_q.delete();
    idle(2);
    reset_n = 1'b1;
    idle(2);
    mount(0, 32'h0010_0000, 1'b0);
    push_read(0, 0, 256, 32'h0010_0000);
    do_xfer(0, 1'b1, 0, 0);
    chk_drained("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
